// File: rtl/tdoa_scheduler_pkg.sv
// rtl/tdoa_scheduler_pkg.sv - shared types and constants for the TDOA engine scheduler
package tdoa_pkg;

   localparam int K_HAT_W   = 8;
   localparam int MAX_PAIRS = 8;

   typedef enum logic [3:0] {
      S_IDLE,
      S_GRANT,
      S_BUSY,
      S_STORE,
      S_ENG_RST_HI,
      S_ENG_RST_LO,
      S_ROUND_DONE,
      S_BUF_RST_HI,
      S_BUF_RST_LO
   } sched_state_t;

endpackage

// File: rtl/tdoa_scheduler_if.sv
// rtl/tdoa_scheduler_if.sv - buffer/engine/aiming-side signal bundle of the scheduler
interface tdoa_scheduler_if #(
   parameter int NUM_PAIRS = 2
);
   import tdoa_pkg::*;

   localparam int SEL_W = $clog2(NUM_PAIRS);

   logic [NUM_PAIRS-1:0]         start_calc;
   logic [NUM_PAIRS-1:0]         finished_calc;
   logic [SEL_W-1:0]             sel;
   logic                         eng_ready;
   logic                         eng_done;
   logic signed [K_HAT_W-1:0]    eng_k_hat;
   logic                         eng_restart;
   logic                         buf_restart;
   logic [NUM_PAIRS*K_HAT_W-1:0] k_hat_all;
   logic                         result_valid;
   logic                         timeout;

   // Scheduler side
   modport slave (
      input  start_calc, eng_done, eng_k_hat,
      output finished_calc, sel, eng_ready, eng_restart, buf_restart,
             k_hat_all, result_valid, timeout
   );

   // Buffers, engine and aiming logic side
   modport master (
      output start_calc, eng_done, eng_k_hat,
      input  finished_calc, sel, eng_ready, eng_restart, buf_restart,
             k_hat_all, result_valid, timeout
   );
endinterface

// File: rtl/tdoa_scheduler_rr_arbiter.sv
// rtl/tdoa_scheduler_rr_arbiter.sv - combinational round-robin pick over pending pairs
module rr_arbiter #(
   parameter int NUM_PAIRS = 2,
   parameter int SEL_W     = $clog2(NUM_PAIRS)
) (
   input  logic [NUM_PAIRS-1:0] pending_i,
   input  logic [SEL_W-1:0]     last_i,
   output logic [NUM_PAIRS-1:0] grant_o,
   output logic [SEL_W-1:0]     idx_o
);

   int   p;
   logic found;

   // Lowest pending index strictly after the last grant, wrapping past the top
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      p       = 0;
      for (int k = 1; k <= NUM_PAIRS; k++) begin
         p = (int'(last_i) + k) % NUM_PAIRS;
         if (!found && pending_i[SEL_W'(p)]) begin
            found                  = 1'b1;
            grant_o[SEL_W'(p)]     = 1'b1;
            idx_o                  = SEL_W'(p);
         end
      end
   end

endmodule

// File: rtl/tdoa_scheduler.sv
// rtl/tdoa_scheduler.sv - round-robin sharing of one TDOA engine across pair buffers (watchdog: TDOA_SCHED_TIMEOUT_EN)
module tdoa_scheduler
   import tdoa_pkg::*;
#(
   parameter int NUM_PAIRS      = 2,
   parameter int RESTART_CYCLES = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input logic              clock,
   input logic              reset,
   tdoa_scheduler_if.slave  bus
);

   localparam int SEL_W = $clog2(NUM_PAIRS);
   localparam int CNT_W = $clog2(RESTART_CYCLES + 1);

   sched_state_t                 state_q;
   logic [NUM_PAIRS-1:0]         pending_q, pending_d;
   logic [NUM_PAIRS-1:0]         captured_q, captured_d;
   logic [SEL_W-1:0]             sel_q, last_q;
   logic [CNT_W-1:0]             rst_cnt_q;
   logic [NUM_PAIRS*K_HAT_W-1:0] stage_q, k_hat_all_q;
   logic [NUM_PAIRS-1:0]         finished_q;
   logic                         eng_ready_q, eng_restart_q, buf_restart_q;
   logic                         result_valid_q, timeout_q;
   logic [NUM_PAIRS-1:0]         grant;
   logic [SEL_W-1:0]             grant_idx;
   logic                         wd_hit;

   rr_arbiter #(.NUM_PAIRS(NUM_PAIRS), .SEL_W(SEL_W)) u_arb (
      .pending_i (pending_q),
      .last_i    (last_q),
      .grant_o   (grant),
      .idx_o     (grant_idx)
   );

   // Requests latch until their pair is stored; a captured pair ignores re-requests
   always_comb begin
      pending_d  = pending_q | (bus.start_calc & ~captured_q);
      captured_d = captured_q;
      if (state_q == S_STORE) begin
         pending_d[sel_q]  = 1'b0;
         captured_d[sel_q] = 1'b1;
      end else if (state_q == S_BUF_RST_LO) begin
         pending_d  = '0;
         captured_d = '0;
      end
   end

   // Main sequencer: grant, wait for engine, store, re-arm engine, publish round, re-arm buffers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         pending_q      <= '0;
         captured_q     <= '0;
         sel_q          <= '0;
         last_q         <= SEL_W'(NUM_PAIRS - 1);
         rst_cnt_q      <= '0;
         stage_q        <= '0;
         k_hat_all_q    <= '0;
         finished_q     <= '0;
         eng_ready_q    <= 1'b0;
         eng_restart_q  <= 1'b0;
         buf_restart_q  <= 1'b0;
         result_valid_q <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         pending_q      <= pending_d;
         captured_q     <= captured_d;
         eng_ready_q    <= 1'b0;
         finished_q     <= '0;
         result_valid_q <= 1'b0;
         timeout_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (wd_hit) begin
                  timeout_q     <= 1'b1;
                  buf_restart_q <= 1'b1;
                  rst_cnt_q     <= '0;
                  state_q       <= S_BUF_RST_HI;
               end else if (|grant) begin
                  sel_q       <= grant_idx;
                  last_q      <= grant_idx;
                  eng_ready_q <= 1'b1;
                  state_q     <= S_GRANT;
               end
            end
            S_GRANT: state_q <= S_BUSY;
            S_BUSY: begin
               if (bus.eng_done) begin
                  stage_q[int'(sel_q)*K_HAT_W +: K_HAT_W] <= bus.eng_k_hat;
                  finished_q[sel_q] <= 1'b1;
                  state_q           <= S_STORE;
               end
            end
            S_STORE: begin
               eng_restart_q <= 1'b1;
               rst_cnt_q     <= '0;
               state_q       <= S_ENG_RST_HI;
            end
            S_ENG_RST_HI: begin
               if (rst_cnt_q == CNT_W'(RESTART_CYCLES - 1)) begin
                  eng_restart_q <= 1'b0;
                  state_q       <= S_ENG_RST_LO;
               end else begin
                  rst_cnt_q <= rst_cnt_q + CNT_W'(1);
               end
            end
            S_ENG_RST_LO: begin
               if (&captured_q) begin
                  k_hat_all_q    <= stage_q;
                  result_valid_q <= 1'b1;
                  state_q        <= S_ROUND_DONE;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_ROUND_DONE: begin
               buf_restart_q <= 1'b1;
               rst_cnt_q     <= '0;
               state_q       <= S_BUF_RST_HI;
            end
            S_BUF_RST_HI: begin
               if (rst_cnt_q == CNT_W'(RESTART_CYCLES - 1)) begin
                  buf_restart_q <= 1'b0;
                  state_q       <= S_BUF_RST_LO;
               end else begin
                  rst_cnt_q <= rst_cnt_q + CNT_W'(1);
               end
            end
            S_BUF_RST_LO: begin
               stage_q <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef TDOA_SCHED_TIMEOUT_EN
   logic [31:0] wd_q;

   // Round watchdog: counts while any pair is in flight, saturates at the limit
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_q <= '0;
      end else if (state_q == S_BUF_RST_LO) begin
         wd_q <= '0;
      end else if ((|pending_q || |captured_q) && wd_q != 32'(TIMEOUT_CYCLES)) begin
         wd_q <= wd_q + 32'd1;
      end
   end

   assign wd_hit      = (state_q == S_IDLE) && (wd_q == 32'(TIMEOUT_CYCLES));
   assign bus.timeout = timeout_q;
`else
   logic unused_timeout_cfg;

   assign wd_hit             = 1'b0;
   assign bus.timeout        = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0) ^ timeout_q;
`endif

   assign bus.finished_calc = finished_q;
   assign bus.sel           = sel_q;
   assign bus.eng_ready     = eng_ready_q;
   assign bus.eng_restart   = eng_restart_q;
   assign bus.buf_restart   = buf_restart_q;
   assign bus.k_hat_all     = k_hat_all_q;
   assign bus.result_valid  = result_valid_q;

endmodule

// File: tb/tb_tdoa_scheduler.sv
// tb/tb_tdoa_scheduler.sv - directed self-checking bench for tdoa_scheduler
module tb_tdoa_scheduler;

   logic clock = 1'b0;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   grants0  = 0;
   int   grants1  = 0;
   int   rv_pulses = 0;

   tdoa_scheduler_if #(.NUM_PAIRS(2)) bus ();

   tdoa_scheduler #(
      .NUM_PAIRS      (2),
      .RESTART_CYCLES (4),
      .TIMEOUT_CYCLES (1000)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Tally grants per pair and result pulses from the cycle that is ending
   always @(posedge clock) begin
      if (!reset) begin
         if (bus.eng_ready) begin
            if (bus.sel == 1'b0) grants0++;
            else                 grants1++;
         end
         if (bus.result_valid) rv_pulses++;
      end
   end

   task automatic step();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_finished"}, 32'(bus.finished_calc), 32'h0);
      chk({tag, "_sel"},      32'(bus.sel),           32'h0);
      chk({tag, "_ready"},    32'(bus.eng_ready),     32'h0);
      chk({tag, "_eng_rst"},  32'(bus.eng_restart),   32'h0);
      chk({tag, "_buf_rst"},  32'(bus.buf_restart),   32'h0);
      chk({tag, "_k_all"},    32'(bus.k_hat_all),     32'h0);
      chk({tag, "_rvalid"},   32'(bus.result_valid),  32'h0);
      chk({tag, "_timeout"},  32'(bus.timeout),       32'h0);
   endtask

   // Engine finishes now; expect finished next cycle, then 4 restart-high cycles and 1 low
   task automatic run_done(input logic [7:0] k, input logic [1:0] fin_exp, input string tag);
      bus.eng_done  = 1'b1;
      bus.eng_k_hat = k;
      step();
      bus.eng_done  = 1'b0;
      bus.eng_k_hat = 8'h00;
      chk({tag, "_finished"}, 32'(bus.finished_calc), 32'(fin_exp));
      for (int i = 0; i < 4; i++) begin
         step();
         chk({tag, "_eng_rst_hi"}, 32'(bus.eng_restart), 32'h1);
      end
      step();
      chk({tag, "_eng_rst_lo"}, 32'(bus.eng_restart), 32'h0);
      chk({tag, "_fin_clear"},  32'(bus.finished_calc), 32'h0);
   endtask

   task automatic buf_restart_seq(input string tag);
      for (int i = 0; i < 4; i++) begin
         step();
         chk({tag, "_buf_rst_hi"}, 32'(bus.buf_restart), 32'h1);
      end
      step();
      chk({tag, "_buf_rst_lo"}, 32'(bus.buf_restart), 32'h0);
      step();
   endtask

   initial begin
      reset          = 1'b1;
      bus.start_calc = 2'b00;
      bus.eng_done   = 1'b0;
      bus.eng_k_hat  = 8'h00;
      repeat (3) step();
      chk_all_zero("reset");
      reset = 1'b0;
      step();

      // Single request on pair 0, engine answers -5 about 100 cycles later
      bus.start_calc = 2'b01;
      step();
      bus.start_calc = 2'b00;
      chk("a_ready_t1", 32'(bus.eng_ready), 32'h0);
      step();
      chk("a_ready_t2", 32'(bus.eng_ready), 32'h1);
      chk("a_sel",      32'(bus.sel),       32'h0);
      step();
      chk("a_ready_busy", 32'(bus.eng_ready), 32'h0);
      repeat (40) step();
      bus.start_calc = 2'b01;
      step();
      bus.start_calc = 2'b00;
      repeat (56) step();
      run_done(8'hFB, 2'b01, "a");
      chk("a_no_rvalid", 32'(rv_pulses), 32'd0);
      step();
      bus.start_calc = 2'b01;
      step();
      bus.start_calc = 2'b00;
      repeat (4) step();
      chk("a_dup_grants", 32'(grants0), 32'd1);
      bus.eng_done  = 1'b1;
      bus.eng_k_hat = 8'h7F;
      step();
      bus.eng_done  = 1'b0;
      bus.eng_k_hat = 8'h00;
      chk("a_stray_done", 32'(bus.finished_calc), 32'h0);

      // Pair 1 completes the round with +17
      bus.start_calc = 2'b10;
      step();
      bus.start_calc = 2'b00;
      chk("b_ready_t1", 32'(bus.eng_ready), 32'h0);
      step();
      chk("b_ready_t2", 32'(bus.eng_ready), 32'h1);
      chk("b_sel",      32'(bus.sel),       32'h1);
      step();
      chk("b_k_all_hold", 32'(bus.k_hat_all), 32'h0);
      repeat (10) step();
      run_done(8'h11, 2'b10, "b");
      step();
      chk("b_rvalid", 32'(bus.result_valid), 32'h1);
      chk("b_k_all",  32'(bus.k_hat_all),    32'h11FB);
      buf_restart_seq("b");
      chk("b_rvalid_count", 32'(rv_pulses), 32'd1);

      // Simultaneous requests: pair 0 first, pair 1 after engine turnaround
      bus.start_calc = 2'b11;
      step();
      bus.start_calc = 2'b00;
      step();
      chk("c_ready0", 32'(bus.eng_ready), 32'h1);
      chk("c_sel0",   32'(bus.sel),       32'h0);
      step();
      repeat (5) step();
      run_done(8'h03, 2'b01, "c0");
      step();
      chk("c_ready_idle", 32'(bus.eng_ready), 32'h0);
      step();
      chk("c_ready1", 32'(bus.eng_ready), 32'h1);
      chk("c_sel1",   32'(bus.sel),       32'h1);
      step();
      repeat (3) step();
      chk("c_k_all_hold", 32'(bus.k_hat_all), 32'h11FB);
      run_done(8'hFF, 2'b10, "c1");
      step();
      chk("c_rvalid", 32'(bus.result_valid), 32'h1);
      chk("c_k_all",  32'(bus.k_hat_all),    32'hFF03);
      buf_restart_seq("c");

`ifdef TDOA_SCHED_TIMEOUT_EN
      // Only pair 1 requests; the watchdog aborts the round
      begin
         int n;
         bus.start_calc = 2'b10;
         step();
         bus.start_calc = 2'b00;
         step();
         chk("to_ready", 32'(bus.eng_ready), 32'h1);
         chk("to_sel",   32'(bus.sel),       32'h1);
         step();
         run_done(8'h22, 2'b10, "to");
         n = 0;
         while (bus.timeout !== 1'b1 && n < 1200) begin
            step();
            n++;
         end
         chk("to_pulse", 32'(bus.timeout),   32'h1);
         chk("to_k_all", 32'(bus.k_hat_all), 32'hFF03);
         buf_restart_seq("to");
         chk("to_no_rvalid", 32'(rv_pulses),     32'd2);
         chk("to_k_all_end", 32'(bus.k_hat_all), 32'hFF03);
      end
`endif

      // Next round's tie starts from pair 0 again
      bus.start_calc = 2'b11;
      step();
      bus.start_calc = 2'b00;
      step();
      chk("d_ready", 32'(bus.eng_ready), 32'h1);
      chk("d_sel",   32'(bus.sel),       32'h0);
      step();
      repeat (3) step();

      // Reset while pair 0 is busy
      reset = 1'b1;
      #1;
      chk_all_zero("midrst");
      step();
      reset = 1'b0;
      bus.start_calc = 2'b11;
      step();
      bus.start_calc = 2'b00;
      step();
      chk("e_ready", 32'(bus.eng_ready), 32'h1);
      chk("e_sel",   32'(bus.sel),       32'h0);
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tdoa_scheduler.md
# tdoa_scheduler

Sequences a single shared TDOA correlation engine across `NUM_PAIRS` microphone-pair capture buffers. Each buffer raises a one-cycle `start_calc` when its noise-triggered capture is centred. The scheduler grants the engine round-robin and steers the engine's address and data mux. It captures each pair's `k_hat`, returns `finished_calc` to the owning buffer, and runs the restart handshakes for both the engine and the buffers. It sits between the per-pair buffers and the turret aiming logic.

## Interface
Parameters:
- `NUM_PAIRS`, default 2: number of buffer pairs sharing the engine (2..8).
- `RESTART_CYCLES`, default 4: high time of each restart pulse (≥1).
- `TIMEOUT_CYCLES`, default 1_000_000: round watchdog limit in clocks.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start_calc`, in, `NUM_PAIRS`: per-pair one-cycle request from a buffer.
- `finished_calc`, out, `NUM_PAIRS`: per-pair one-cycle completion to the buffer. Reset value 0.
- `sel`, out, `$clog2(NUM_PAIRS)`: engine mux select; stable from GRANT through STORE. Reset value 0.
- `eng_ready`, out, 1: one-cycle start to the engine. Reset value 0.
- `eng_done`, in, 1: one-cycle completion from the engine.
- `eng_k_hat`, in, 8 signed: engine result; valid while `eng_done` is high.
- `eng_restart`, out, 1: engine re-arm pulse. Reset value 0.
- `buf_restart`, out, 1: buffer re-arm pulse, shared by all buffers. Reset value 0.
- `k_hat_all`, out, `NUM_PAIRS*8`: packed signed results; pair i occupies bits [8i+7:8i]. Reset value 0.
- `result_valid`, out, 1: one-cycle pulse when `k_hat_all` updates. Reset value 0.
- `timeout`, out, 1: one-cycle pulse when the watchdog aborts a round. Reset value 0.

## Operation
- Request tracking:
  - `pending[i]` sets when `start_calc[i]` is high and `captured[i]` is 0.
  - `pending[i]` clears in STORE for pair i.
  - A request on a pair already pending or already captured is ignored.
- FSM states: IDLE, GRANT, BUSY, STORE, ENG_RST_HI, ENG_RST_LO, ROUND_DONE, BUF_RST_HI, BUF_RST_LO.
- IDLE: if `pending` is nonzero, go to GRANT. `sel` is registered from the round-robin pick: the lowest pending index strictly after the last grant, wrapping.
- GRANT: assert `eng_ready` for one cycle, then go to BUSY.
- BUSY: wait for `eng_done`. On `eng_done`, latch `eng_k_hat` into the staging slot for `sel` and go to STORE.
- STORE:
  - Pulse `finished_calc[sel]`.
  - Set `captured[sel]` and clear `pending[sel]`.
  - Go to ENG_RST_HI.
- ENG_RST_HI: hold `eng_restart` high for `RESTART_CYCLES` cycles, then go to ENG_RST_LO.
- ENG_RST_LO: one cycle with `eng_restart` low. Then go to ROUND_DONE if `captured` is all ones, else IDLE.
- ROUND_DONE:
  - Copy the staging slots to `k_hat_all` and pulse `result_valid` in the same cycle.
  - Go to BUF_RST_HI.
- BUF_RST_HI / BUF_RST_LO:
  - Hold `buf_restart` high for `RESTART_CYCLES` cycles, then low for one cycle.
  - Clear `captured`, `pending` and the staging slots, then go to IDLE.
- Round-robin pointer: updates only on grant; reset value points to `NUM_PAIRS-1`, so pair 0 wins first.
- `k_hat_all` holds its previous round's value until the next ROUND_DONE.
- Reset mid-operation: all state and outputs return to their reset values immediately. The engine and buffers share the same `reset`; no restart pulse is issued on reset.

## Timing
- Request to grant: `start_calc` high at cycle t sets `pending` at t+1; the FSM enters GRANT and `eng_ready` is high at t+2, when the FSM is in IDLE at t+1.
- `sel` changes only on the IDLE→GRANT transition.
- `eng_done` to `finished_calc`: 1 cycle.
- Engine turnaround: `eng_done` to the next possible `eng_ready` is `RESTART_CYCLES + 4` cycles.
- `start_calc` arriving during BUSY or a restart state is registered and never lost.
- `eng_done` outside BUSY is ignored.

## Configuration
- `TDOA_SCHED_TIMEOUT_EN` defined:
  - A counter runs while any `pending` or `captured` bit is set and clears in BUF_RST_LO.
  - When it reaches `TIMEOUT_CYCLES` in IDLE, pulse `timeout` and go to BUF_RST_HI.
  - Partial results are discarded: `k_hat_all` is unchanged and `result_valid` is not pulsed.
  - A timeout in BUSY waits for `eng_done` and completes the pair first.
- `TDOA_SCHED_TIMEOUT_EN` undefined: no counter; `timeout` is tied 0; a round waits indefinitely.

## Structure
- Package `tdoa_pkg`: the `sched_state_t` enum, `K_HAT_W = 8`, `MAX_PAIRS = 8`.
- Sub-module `rr_arbiter`: pending vector plus last-grant pointer in, one-hot grant and encoded index out; purely combinational pick.

## Test plan
- Single request, `NUM_PAIRS=2`: `start_calc=2'b01`; engine returns `k_hat=-5` after 100 cycles.
  - `eng_ready` at t+2 with `sel=0`; `finished_calc=2'b01` one cycle after `eng_done`.
  - `eng_restart` high 4 cycles; no `result_valid` yet.
- Full round: then `start_calc=2'b10`, `k_hat=+17`.
  - `result_valid` pulses with `k_hat_all=16'h11FB`.
  - `buf_restart` high 4 cycles, then the FSM returns to IDLE.
- Simultaneous: `start_calc=2'b11` in one cycle.
  - Pair 0 is granted first; pair 1 is granted after pair 0's ENG_RST_LO.
  - Next round's tie also resolves starting from pair 0 after the buffer reset.
- Duplicate request: re-pulse `start_calc[0]` while pair 0 is BUSY or captured → no second grant to pair 0.
- With `TDOA_SCHED_TIMEOUT_EN`, `TIMEOUT_CYCLES=1000`: only pair 1 requests.
  - `timeout` pulses, `buf_restart` fires, `k_hat_all` is unchanged, no `result_valid`.
- Assert `reset` while in BUSY → all outputs 0 and FSM in IDLE within the same cycle; a new request after release grants pair 0.
